// File: rtl/mem_lane_unit.sv
// mem_lane_unit: byte-lane steering between the M-stage load/store port and
// data memory. Produces byte enables and lane-shifted store data, merges and
// sign/zero-extends load data, and either splits word-boundary-crossing
// accesses into two memory beats or reports them as address exceptions.
module mem_lane_unit #(
  parameter int DATA_W          = 32,
  parameter bit ALLOW_UNALIGNED = 1'b0,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_exc,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int NB = DATA_W / 8;     // byte lanes
  localparam int OW = $clog2(NB);     // lane-offset bits
  localparam int CW = 5;              // wide enough for off + nbytes (max 15)
  localparam int SW = CW + 3;         // bit-shift amount width
  localparam int BW = 2 * NB;         // byte enables across two beats

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                exc_q, exc_d;
  logic [DATA_W-1:0]   rd0_q, rd0_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d;

  // Decode of the incoming request, used to pick the exception path at accept.
  logic [CW-1:0] in_nbytes, in_off;
  logic          in_cross, in_misal, in_exc;

  assign in_nbytes = CW'(1) << req_size;
  assign in_off    = CW'(req_addr[OW-1:0]);
  assign in_cross  = (in_off + in_nbytes) > CW'(NB);
  assign in_misal  = (in_off & (in_nbytes - CW'(1))) != '0;
  assign in_exc    = (in_nbytes > CW'(NB)) || (!ALLOW_UNALIGNED && (in_cross || in_misal));

  // Decode of the captured access, which drives both beats and the merge.
  logic [CW-1:0]       nbytes_w, off_w;
  logic                cross_w;
  logic [SW-1:0]       bit_sh, bit_sh_hi;
  logic [BW-1:0]       be_wide;
  logic [2*DATA_W-1:0] wd_wide;
  logic [ADDR_W-1:0]   beat_base;

  assign nbytes_w  = CW'(1) << size_q;
  assign off_w     = CW'(addr_q[OW-1:0]);
  assign cross_w   = (off_w + nbytes_w) > CW'(NB);
  assign bit_sh    = {off_w, 3'b000};
  assign bit_sh_hi = SW'(DATA_W) - bit_sh;
  // Low half of each wide vector is beat 0, high half is the spill into beat 1.
  assign be_wide   = ((BW'(1) << nbytes_w) - BW'(1)) << off_w;
  assign wd_wide   = {{DATA_W{1'b0}}, wdata_q} << bit_sh;
  assign beat_base = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};

  // Load merge: beat-0 bytes shifted down, beat-1 bytes filling the top.
  logic [DATA_W-1:0] raw, ext;
  logic [NB-1:0]     lane_msb;
  logic              sign_bit;

  assign raw      = (rd0_q >> bit_sh) | (cross_w ? (rd1_q << bit_sh_hi) : '0);
  assign sign_bit = signed_q && lane_msb[OW'(nbytes_w - CW'(1))];

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign lane_msb[gi]     = raw[8*gi+7];
    assign ext[8*gi +: 8]   = (CW'(gi) < nbytes_w) ? raw[8*gi +: 8] : {8{sign_bit}};
  end

  // Beat FSM: next state, request capture and all handshake outputs.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    signed_d  = signed_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    exc_d     = exc_q;
    rd0_d     = rd0_q;
    rd1_d     = rd1_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_exc   = 1'b0;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          exc_d    = in_exc;
          state_d  = in_exc ? RESP : BEAT0;
        end
      end
      BEAT0: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = beat_base;
        mem_be    = be_wide[NB-1:0];
        mem_wdata = wd_wide[DATA_W-1:0];
        if (mem_ready) begin
          rd0_d   = mem_rdata;
          state_d = cross_w ? BEAT1 : RESP;
        end
      end
      BEAT1: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = beat_base + ADDR_W'(NB);
        mem_be    = be_wide[BW-1:NB];
        mem_wdata = wd_wide[2*DATA_W-1:DATA_W];
        if (mem_ready) begin
          rd1_d   = mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_exc   = exc_q;
        rsp_rdata = (we_q || exc_q) ? '0 : ext;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      exc_q    <= 1'b0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      exc_q    <= exc_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
    end
  end

endmodule

// File: tb/tb_mem_lane_unit.sv
// Bench for mem_lane_unit: three instances (32-bit aligned-only, 32-bit
// unaligned-splitting, 64-bit unaligned-splitting) share one stimulus bus,
// selected by sel. A byte-level reference model predicts every beat and
// response; a negedge monitor compares the selected instance against it.
module tb_mem_lane_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, mem_ready = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0, mem_rdata = '0;
  int          sel = 0;

  always #5 clk = ~clk;

  // Per-instance outputs
  logic        a_req_ready, a_rsp_valid, a_rsp_exc, a_mem_valid, a_mem_we;
  logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic        u_req_ready, u_rsp_valid, u_rsp_exc, u_mem_valid, u_mem_we;
  logic [31:0] u_rsp_rdata, u_mem_addr, u_mem_wdata;
  logic [3:0]  u_mem_be;
  logic        w_req_ready, w_rsp_valid, w_rsp_exc, w_mem_valid, w_mem_we;
  logic [63:0] w_rsp_rdata, w_mem_wdata;
  logic [31:0] w_mem_addr;
  logic [7:0]  w_mem_be;
  logic        a_req_valid, u_req_valid, w_req_valid;

  assign a_req_valid = req_valid && (sel == 0);
  assign u_req_valid = req_valid && (sel == 1);
  assign w_req_valid = req_valid && (sel == 2);

  mem_lane_unit #(.DATA_W(32), .ALLOW_UNALIGNED(1'b0), .ADDR_W(32)) dut_a (
    .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .rsp_exc(a_rsp_exc), .mem_valid(a_mem_valid), .mem_ready(mem_ready), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_be(a_mem_be), .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata[31:0]));

  mem_lane_unit #(.DATA_W(32), .ALLOW_UNALIGNED(1'b1), .ADDR_W(32)) dut_u (
    .clk(clk), .reset(reset), .req_valid(u_req_valid), .req_ready(u_req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .rsp_valid(u_rsp_valid), .rsp_rdata(u_rsp_rdata),
    .rsp_exc(u_rsp_exc), .mem_valid(u_mem_valid), .mem_ready(mem_ready), .mem_we(u_mem_we),
    .mem_addr(u_mem_addr), .mem_be(u_mem_be), .mem_wdata(u_mem_wdata), .mem_rdata(mem_rdata[31:0]));

  mem_lane_unit #(.DATA_W(64), .ALLOW_UNALIGNED(1'b1), .ADDR_W(32)) dut_w (
    .clk(clk), .reset(reset), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(w_rsp_valid), .rsp_rdata(w_rsp_rdata),
    .rsp_exc(w_rsp_exc), .mem_valid(w_mem_valid), .mem_ready(mem_ready), .mem_we(w_mem_we),
    .mem_addr(w_mem_addr), .mem_be(w_mem_be), .mem_wdata(w_mem_wdata), .mem_rdata(mem_rdata));

  // Outputs of the selected instance, zero-extended to the widest form
  logic        req_ready, rsp_valid, rsp_exc, mem_valid, mem_we;
  logic [63:0] rsp_rdata, mem_wdata;
  logic [31:0] mem_addr;
  logic [7:0]  mem_be;

  always_comb begin
    case (sel)
      1: begin
        req_ready = u_req_ready; rsp_valid = u_rsp_valid; rsp_exc = u_rsp_exc;
        mem_valid = u_mem_valid; mem_we = u_mem_we; mem_addr = u_mem_addr;
        mem_be = {4'b0, u_mem_be}; mem_wdata = {32'b0, u_mem_wdata}; rsp_rdata = {32'b0, u_rsp_rdata};
      end
      2: begin
        req_ready = w_req_ready; rsp_valid = w_rsp_valid; rsp_exc = w_rsp_exc;
        mem_valid = w_mem_valid; mem_we = w_mem_we; mem_addr = w_mem_addr;
        mem_be = w_mem_be; mem_wdata = w_mem_wdata; rsp_rdata = w_rsp_rdata;
      end
      default: begin
        req_ready = a_req_ready; rsp_valid = a_rsp_valid; rsp_exc = a_rsp_exc;
        mem_valid = a_mem_valid; mem_we = a_mem_we; mem_addr = a_mem_addr;
        mem_be = {4'b0, a_mem_be}; mem_wdata = {32'b0, a_mem_wdata}; rsp_rdata = {32'b0, a_rsp_rdata};
      end
    endcase
  end

  int n_checks = 0, n_pass = 0, n_tx = 0, cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: byte-by-byte placement of an access into NB-wide beats
  bit        m_exc, m_we;
  int        m_nbeats;
  bit [31:0] m_addr[2];
  bit [7:0]  m_be[2];
  bit [63:0] m_wd[2];
  bit [63:0] m_rd[2];
  bit [63:0] m_rdata;

  task automatic model(input int s, input bit we, input bit [1:0] size, input bit sgn,
                       input bit [31:0] addr, input bit [63:0] wd, input bit [63:0] r0, input bit [63:0] r1);
    int nb, nbytes, off, pos;
    bit au;
    bit [63:0] res;
    nb = (s == 2) ? 8 : 4;
    au = (s != 0);
    nbytes = 1 << size;
    off = int'(addr % nb);
    m_we = we;
    m_exc = (nbytes > nb) || (!au && ((off + nbytes > nb) || (off % nbytes != 0)));
    m_nbeats = m_exc ? 0 : ((off + nbytes > nb) ? 2 : 1);
    m_rd[0] = r0;
    m_rd[1] = r1;
    for (int b = 0; b < 2; b++) begin
      m_addr[b] = addr - 32'(off) + 32'(b * nb);
      m_be[b] = '0;
      m_wd[b] = '0;
    end
    res = '0;
    for (int k = 0; k < nb; k++) begin
      pos = off + k;
      m_wd[pos / nb][8*(pos % nb) +: 8] = wd[8*k +: 8];
      if (k < nbytes) begin
        m_be[pos / nb][pos % nb] = 1'b1;
        res[8*k +: 8] = m_rd[pos / nb][8*(pos % nb) +: 8];
      end
    end
    if (sgn && nbytes < nb && res[8*nbytes-1])
      for (int j = 8*nbytes; j < 8*nb; j++) res[j] = 1'b1;
    m_rdata = (we || m_exc) ? 64'd0 : res;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle, compare the selected DUT with the model
  bit busy = 1'b0;
  int beat_idx = 0, waits = 0, acc_cyc = 0;

  always @(negedge clk) begin
    if (reset) begin
      busy = 1'b0;
    end else begin
      chk("req_ready", 64'(req_ready), 64'(!busy));
      if (mem_valid) begin
        if (!busy || beat_idx >= m_nbeats) chk("spurious_mem_valid", 64'(mem_valid), 64'd0);
        else begin
          chk("mem_we", 64'(mem_we), 64'(m_we));
          chk("mem_addr", 64'(mem_addr), 64'(m_addr[beat_idx]));
          chk("mem_be", 64'(mem_be), 64'(m_be[beat_idx]));
          chk("mem_wdata", mem_wdata, m_wd[beat_idx]);
          if (mem_ready) beat_idx++;
          else waits++;
        end
      end
      if (rsp_valid) begin
        if (!busy) chk("spurious_rsp_valid", 64'(rsp_valid), 64'd0);
        else begin
          chk("rsp_exc", 64'(rsp_exc), 64'(m_exc));
          chk("rsp_rdata", rsp_rdata, m_rdata);
          chk("beats_done", 64'(beat_idx), 64'(m_nbeats));
          chk("latency", 64'(cyc - acc_cyc), 64'(1 + m_nbeats + waits));
          $display("tx %0d: sel=%0d we=%0b size=%0d addr=%08h exc=%0b rdata=%016h beats=%0d waits=%0d",
                   n_tx, sel, req_we, req_size, req_addr, rsp_exc, rsp_rdata, beat_idx, waits);
          busy = 1'b0;
          n_tx++;
        end
      end else if (!busy && req_valid && req_ready) begin
        busy = 1'b1;
        acc_cyc = cyc;
        beat_idx = 0;
        waits = 0;
      end
    end
  end

  // Driver. mode: 0 random mem_ready, 1 always ready, 2 three stall cycles,
  // 3 complete beat 0 then hold off and reset in beat 1.
  task automatic run_tx(input int s, input bit we, input bit [1:0] size, input bit sgn,
                        input bit [31:0] addr, input bit [63:0] wd, input bit [63:0] r0,
                        input bit [63:0] r1, input int mode);
    int cnt;
    sel = s;
    model(s, we, size, sgn, addr, wd, r0, r1);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!busy && cnt < 20);
    req_valid = 1'b0;
    if (!busy) begin
      chk("accept_timeout", 64'd0, 64'd1);
      return;
    end
    cnt = 0;
    while (busy && cnt < 60) begin
      case (mode)
        1: mem_ready = 1'b1;
        2: mem_ready = (cnt >= 3);
        3: mem_ready = (beat_idx == 0);
        default: mem_ready = ($urandom_range(0, 3) != 0);
      endcase
      mem_rdata = m_rd[(beat_idx > 1) ? 1 : beat_idx];
      if (mode == 3 && beat_idx == 1) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        chk("abort_mem_valid", 64'(mem_valid), 64'd0);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        $display("tx abort: sel=%0d addr=%08h reset in beat 1", sel, addr);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      cnt++;
    end
    mem_ready = 1'b0;
    if (mode == 3 && busy) chk("abort_not_reached", 64'd0, 64'd1);
    if (busy) begin
      chk("rsp_timeout", 64'd0, 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] ad;
    int s;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready_a", 64'(a_req_ready), 64'd1);
    chk("reset_req_ready_u", 64'(u_req_ready), 64'd1);
    chk("reset_req_ready_w", 64'(w_req_ready), 64'd1);
    chk("reset_mem_valid", 64'({a_mem_valid, u_mem_valid, w_mem_valid}), 64'd0);
    chk("reset_rsp_valid", 64'({a_rsp_valid, u_rsp_valid, w_rsp_valid}), 64'd0);
    chk("reset_mem_be_w", 64'(w_mem_be), 64'd0);
    chk("reset_rsp_rdata_u", 64'(u_rsp_rdata), 64'd0);

    // Hand-computed values that pin the model
    model(0, 1, 0, 0, 32'h1003, 64'hAB, 0, 0);
    chk("pin_sb_be", 64'(m_be[0]), 64'h8);
    chk("pin_sb_wd", m_wd[0], 64'hAB000000);
    chk("pin_sb_addr", 64'(m_addr[0]), 64'h1000);
    model(0, 0, 1, 1, 32'h2002, 0, 64'h80011234, 0);
    chk("pin_lh_signed", m_rdata, 64'hFFFF8001);
    model(0, 0, 1, 0, 32'h2002, 0, 64'h80011234, 0);
    chk("pin_lh_unsigned", m_rdata, 64'h00008001);
    model(0, 0, 2, 0, 32'h3001, 0, 0, 0);
    chk("pin_lw_exc", 64'({m_exc, 8'(m_nbeats)}), 64'h100);
    model(1, 1, 2, 0, 32'h4003, 64'h11223344, 0, 0);
    chk("pin_split_be", 64'({m_be[1], m_be[0]}), 64'h0708);
    chk("pin_split_wd0", m_wd[0], 64'h44000000);
    chk("pin_split_wd1", m_wd[1], 64'h00112233);
    chk("pin_split_addr1", 64'(m_addr[1]), 64'h4004);
    model(1, 0, 2, 0, 32'h5002, 0, 64'hAAAA0000, 64'h0000BBBB);
    chk("pin_split_load", m_rdata, 64'hBBBBAAAA);
    model(2, 0, 3, 0, 32'h1008, 0, 0, 0);
    chk("pin_dword_be", 64'(m_be[0]), 64'hFF);

    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases
    run_tx(0, 1, 0, 0, 32'h1003, 64'h000000AB, 0, 0, 1);
    run_tx(0, 0, 1, 1, 32'h2002, 0, 64'h80011234, 0, 2);
    run_tx(0, 0, 1, 0, 32'h2002, 0, 64'h80011234, 0, 2);
    run_tx(0, 0, 2, 0, 32'h3001, 0, 0, 0, 1);
    run_tx(0, 1, 1, 0, 32'h3003, 64'h5566, 0, 0, 1);
    run_tx(1, 1, 2, 0, 32'h4003, 64'h11223344, 0, 0, 1);
    run_tx(1, 0, 2, 0, 32'h5002, 0, 64'hAAAA0000, 64'h0000BBBB, 1);
    run_tx(1, 0, 2, 0, 32'h4003, 0, 64'h12345678, 64'h9ABCDEF0, 3);
    repeat (3) @(posedge clk);
    #1;
    run_tx(1, 0, 2, 1, 32'h6000, 0, 64'h87654321, 0, 1);
    run_tx(2, 0, 3, 1, 32'h00001008, 0, 64'h0123456789ABCDEF, 0, 1);
    run_tx(2, 1, 3, 0, 32'h0000100B, 64'hCAFEF00DDEADBEEF, 0, 0, 1);
    run_tx(1, 0, 2, 1, 32'hFFFFFFFE, 0, 64'h80000000, 64'h00000001, 1);
    run_tx(2, 0, 1, 1, 32'h00000007, 0, 64'hFF00000000000000, 64'h80, 1);

    // Randomized traffic across all three configurations
    for (int i = 0; i < 300; i++) begin
      s = $urandom_range(0, 2);
      ad = $urandom;
      if ($urandom_range(0, 7) == 0) ad = 32'hFFFFFFF8 | 32'($urandom_range(0, 7));
      run_tx(s, 1'($urandom), 2'($urandom), 1'($urandom), ad, {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom}, 0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
